// File: rtl/timer_irq.sv
// timer_irq: memory-mapped interval timer that raises the CPU interrupt request.
//
// Registers (word addresses relative to BASE_ADDR):
//   +0 TH   : 32-bit reload value
//   +4 TL   : 32-bit up-counter
//   +8 TCON : [0] EN count enable, [1] IEN interrupt enable, [2] STAT pending
//
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   addr, wdata  : data-bus byte address and write data
//   mem_wr       : bus write strobe
//   mem_rd       : bus read strobe
//   rdata        : combinational read data, 0 when not reading a mapped register
//   kernel_mode  : PC[31]; masks irq while the handler runs
//   irq          : STAT & IEN & ~kernel_mode
module timer_irq #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_wr,
    input  logic        mem_rd,
    output logic [31:0] rdata,
    input  logic        kernel_mode,
    output logic        irq
);

    localparam int          PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [31:0]   th, tl;
    logic          en, ien, stat;
    logic [PW-1:0] pcnt;

    logic hit_th, hit_tl, hit_tcon;
    logic wr_th, wr_tl, wr_tcon;
    logic tick, ovf, stat_set;

    // Exact word match; any non-zero low address bits miss.
    assign hit_th   = (addr == BASE_ADDR);
    assign hit_tl   = (addr == BASE_ADDR + 32'd4);
    assign hit_tcon = (addr == BASE_ADDR + 32'd8);

    assign wr_th   = mem_wr & hit_th;
    assign wr_tl   = mem_wr & hit_tl;
    assign wr_tcon = mem_wr & hit_tcon;

    assign tick = en & (pcnt == PMAX);
    assign ovf  = tick & (tl == 32'hFFFF_FFFF);
    // A software TL write swallows the tick, so it cannot raise STAT either.
    assign stat_set = ovf & ien & ~wr_tl;

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
        end else if (!en || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th   <= '0;
            tl   <= '0;
            en   <= 1'b0;
            ien  <= 1'b0;
            stat <= 1'b0;
        end else begin
            if (wr_th) th <= wdata;

            // Reload reads the pre-edge TH, so a same-cycle TH write applies next time.
            if (wr_tl)      tl <= wdata;
            else if (ovf)   tl <= th;
            else if (tick)  tl <= tl + 32'd1;

            if (wr_tcon) begin
                en   <= wdata[0];
                ien  <= wdata[1];
                // A hardware overflow in the same cycle is never lost to a write.
                stat <= wdata[2] | stat_set;
            end else if (stat_set) begin
                stat <= 1'b1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (mem_rd) begin
            if (hit_th)        rdata = th;
            else if (hit_tl)   rdata = tl;
            else if (hit_tcon) rdata = {29'd0, stat, ien, en};
        end
    end

    assign irq = stat & ien & ~kernel_mode;

endmodule

// File: tb/tb_timer_irq.sv
module tb_timer_irq;

    localparam logic [31:0] BA   = 32'h4000_0000;
    localparam logic [31:0] A_TH = BA;
    localparam logic [31:0] A_TL = BA + 32'd4;
    localparam logic [31:0] A_TC = BA + 32'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        wr1 = 1'b0, wr4 = 1'b0;
    logic        rd = 1'b0;
    logic        kernel_mode = 1'b0;
    logic [31:0] rdata1, rdata4;
    logic        irq1, irq4;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    timer_irq #(.BASE_ADDR(BA), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .mem_wr(wr1), .mem_rd(rd), .rdata(rdata1),
        .kernel_mode(kernel_mode), .irq(irq1)
    );

    timer_irq #(.BASE_ADDR(BA), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .mem_wr(wr4), .mem_rd(rd), .rdata(rdata4),
        .kernel_mode(kernel_mode), .irq(irq4)
    );

    // Inputs change 1ns after the rising edge; outputs are sampled 3ns after it.
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input bit which, input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        if (which) wr4 = 1'b1; else wr1 = 1'b1;
        cyc();
        wr1 = 1'b0;
        wr4 = 1'b0;
    endtask

    task automatic compare(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", t, obs, e);
        end
    endtask

    task automatic chk_rd(input bit which, input logic [31:0] a, input logic [31:0] e,
                          input string t, input bit strobe = 1'b1);
        exp_q.push_back(e);
        tag_q.push_back(t);
        addr = a;
        rd   = strobe;
        #2;
        compare(which ? rdata4 : rdata1);
        rd = 1'b0;
    endtask

    task automatic chk_irq(input bit which, input logic e, input string t);
        exp_q.push_back({31'd0, e});
        tag_q.push_back(t);
        #2;
        compare({31'd0, which ? irq4 : irq1});
    endtask

    initial begin
        cyc(2);
        reset = 1'b0;

        // Reset state
        chk_rd(0, A_TH, 32'h0, "rst_th");
        chk_rd(0, A_TL, 32'h0, "rst_tl");
        chk_rd(0, A_TC, 32'h0, "rst_tcon");
        chk_rd(1, A_TC, 32'h0, "rst_tcon4");
        for (int i = 0; i < 10; i++) begin
            chk_irq(0, 1'b0, "rst_irq");
            cyc();
        end

        // Overflow and reload, PRESCALE=1
        wr(0, A_TH, 32'hFFFF_FFFC);
        wr(0, A_TL, 32'hFFFF_FFFE);
        wr(0, A_TC, 32'h3);
        cyc();
        chk_rd(0, A_TL, 32'hFFFF_FFFF, "tl_ff");
        chk_irq(0, 1'b0, "irq_pre_ovf");
        cyc();
        chk_rd(0, A_TL, 32'hFFFF_FFFC, "tl_reload");
        chk_rd(0, A_TC, 32'h7, "stat_set");
        chk_irq(0, 1'b1, "irq_ovf");
        cyc(3);
        chk_rd(0, A_TL, 32'hFFFF_FFFF, "tl_ff_2");
        cyc();
        chk_rd(0, A_TL, 32'hFFFF_FFFC, "tl_reload_2");

        // Kernel-mode masking and software clear
        kernel_mode = 1'b1;
        chk_irq(0, 1'b0, "irq_kmask");
        wr(0, A_TC, 32'h3);
        kernel_mode = 1'b0;
        chk_irq(0, 1'b0, "irq_cleared");
        chk_rd(0, A_TC, 32'h3, "tcon_cleared");
        chk_rd(0, A_TL, 32'hFFFF_FFFD, "tl_fd");
        cyc();
        chk_irq(0, 1'b0, "irq_wait1");
        cyc();
        chk_irq(0, 1'b0, "irq_wait2");
        chk_rd(0, A_TL, 32'hFFFF_FFFF, "tl_ff_3");

        // TCON write in the overflow cycle keeps the event
        wr(0, A_TC, 32'h3);
        chk_rd(0, A_TC, 32'h7, "tcon_wr_ovf");
        chk_rd(0, A_TL, 32'hFFFF_FFFC, "tl_reload_3");
        chk_irq(0, 1'b1, "irq_tcon_wr_ovf");

        // TL write in the overflow cycle wins, STAT untouched
        wr(0, A_TC, 32'h3);
        cyc(2);
        chk_rd(0, A_TL, 32'hFFFF_FFFF, "tl_ff_4");
        wr(0, A_TL, 32'h10);
        chk_rd(0, A_TL, 32'h10, "tl_wr_wins");
        chk_rd(0, A_TC, 32'h3, "tl_wr_no_stat");
        chk_irq(0, 1'b0, "tl_wr_no_irq");
        wr(0, A_TC, 32'h0);

        // PRESCALE=4
        wr(1, A_TC, 32'h1);
        cyc(3);
        chk_rd(1, A_TL, 32'h0, "p4_tl0");
        cyc();
        chk_rd(1, A_TL, 32'h1, "p4_tl1");
        cyc(3);
        chk_rd(1, A_TL, 32'h1, "p4_tl1b");
        cyc();
        chk_rd(1, A_TL, 32'h2, "p4_tl2");
        cyc(2);
        wr(1, A_TC, 32'h0);
        cyc(2);
        chk_rd(1, A_TL, 32'h2, "p4_held");
        wr(1, A_TC, 32'h1);
        cyc(3);
        chk_rd(1, A_TL, 32'h2, "p4_presc_clr");
        cyc();
        chk_rd(1, A_TL, 32'h3, "p4_tl3");

        // Reset mid-count with a pending STAT
        wr(0, A_TL, 32'h1234);
        wr(0, A_TC, 32'h6);
        chk_irq(0, 1'b1, "pre_rst_irq");
        chk_rd(0, A_TL, 32'h1234, "pre_rst_tl");
        chk_rd(0, A_TL, 32'h0, "rd_strobe_off", 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_rd(0, A_TL, 32'h0, "post_rst_tl");
        chk_rd(0, A_TC, 32'h0, "post_rst_tcon");
        chk_irq(0, 1'b0, "post_rst_irq");
        chk_rd(1, A_TL, 32'h0, "post_rst_tl4");

        // Unmapped and misaligned addresses
        wr(0, BA + 32'd12, 32'hDEAD_BEEF);
        wr(0, BA + 32'd1, 32'h7);
        wr(0, BA + 32'd6, 32'h55);
        chk_rd(0, A_TH, 32'h0, "unmap_th");
        chk_rd(0, A_TL, 32'h0, "unmap_tl");
        chk_rd(0, A_TC, 32'h0, "unmap_tcon");
        chk_rd(0, BA + 32'd12, 32'h0, "unmap_rd");
        wr(0, A_TH, 32'hA5A5_0001);
        chk_rd(0, A_TH, 32'hA5A5_0001, "th_rd");
        chk_rd(0, BA + 32'd1, 32'h0, "misalign_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_irq.md
Name: timer_irq

Overview:
- Memory-mapped interval timer that generates the IRQ input consumed by the instruction decoder/control stage. Raising IRQ makes control select PCSrc=3'b100, the interrupt vector.
- Sits on the data-memory bus beside data RAM.
- The CPU programs a reload value and a counter. On counter overflow the block reloads the counter and latches an interrupt status bit.
- The interrupt request is masked while the CPU runs in kernel mode (PC[31]=1), so the handler cannot be re-entered.

Parameters:
- BASE_ADDR, 32'h40000000, byte address of TH. TL is at BASE_ADDR+4; TCON is at BASE_ADDR+8.
- PRESCALE, 1, clock cycles per counter tick. Must be at least 1. A value of 1 ticks every enabled cycle.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  data-bus byte address, from the ALU result.
- wdata  in  32  data-bus write data.
- mem_wr  in  1  bus write strobe, from MemWr.
- mem_rd  in  1  bus read strobe, from MemRd.
- rdata  out  32  read data for mapped registers.
- kernel_mode  in  1  current PC[31]; 1 means the CPU is in the handler or exception code.
- irq  out  1  interrupt request to control.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high; it is sampled on the rising edge of clk.
- Reset values: TH=0, TL=0, TCON=3'b000, prescaler count=0. After reset, irq=0 and rdata=0.
- Registers:
  - TH (32 bit): reload value.
  - TL (32 bit): counter.
  - TCON[0]: EN, count enable.
  - TCON[1]: IEN, interrupt enable.
  - TCON[2]: STAT, interrupt pending.
  - TCON bits 31:3 read as 0.
- Address decode: exact word-address match on addr. addr[1:0] must be 00; non-zero low bits mean no hit. Unmapped addresses: writes are ignored and rdata=0.
- Read: combinational, same cycle.
  - rdata = selected register when mem_rd=1 and the address hits.
  - Otherwise rdata=0.
- Write: takes effect on the rising edge while mem_wr=1 and the address hits. A TCON write loads wdata[2:0].
- Prescaler, when EN=1:
  - The prescaler counts 0..PRESCALE-1.
  - tick=1 in the cycle the count equals PRESCALE-1; the count then wraps to 0.
  - With PRESCALE=1, tick=1 every cycle.
- Prescaler, when EN=0: the prescaler is held at 0 and tick=0.
- Counter on tick:
  - If TL != 32'hFFFFFFFF, TL <= TL+1, with 32-bit unsigned arithmetic.
  - If TL == 32'hFFFFFFFF (overflow), TL <= TH. If IEN=1, STAT <= 1 as well.
  - If IEN=0, an overflow reloads TL but leaves STAT unchanged.
- Simultaneous events:
  - A TL write and a tick in the same cycle: the write wins. TL=wdata, and there is no reload or STAT set from that tick.
  - A TH write and an overflow in the same cycle: the reload uses the old TH; the new TH applies from the next overflow.
  - A TCON write and an overflow (with IEN=1) in the same cycle: TCON[1:0]=wdata[1:0] and STAT=1. A pending event is never lost.
  - A TCON write that sets EN=0: counting stops from the next cycle and the prescaler clears.
- irq = STAT & IEN & ~kernel_mode. It is combinational, with no added latency from the STAT register output.
  - irq stays asserted until software clears STAT or IEN.
  - irq drops immediately while kernel_mode=1.
- Reset mid-count: all state returns to reset values on that edge. A pending STAT is discarded.
- Latency from overflow to irq:
  - STAT is set on the overflow edge.
  - irq is high in the first cycle after that edge, provided kernel_mode=0.

Test Plan:
- Reset, then read TH/TL/TCON -> all 0; irq=0 for 10 cycles.
- PRESCALE=1. Write TH=32'hFFFFFFFC, TL=32'hFFFFFFFE, TCON=3'b011.
  -> TL reads FFFFFFFF after 1 cycle.
  -> TL reads FFFFFFFC after 2 cycles, with STAT=1 and irq=1.
  -> The next overflow occurs 4 cycles later.
- With irq=1, drive kernel_mode=1 -> irq=0 the same cycle. Write TCON=3'b011, then drop kernel_mode -> irq stays 0 until the next overflow.
- In the overflow cycle, write TCON=3'b011 -> STAT reads 1 afterwards.
  - Separately, write TL=32'h10 in a tick cycle where TL=FFFFFFFF -> TL reads 10 and STAT is unchanged.
- PRESCALE=4, EN=1, TL=0 -> TL reads 1 after 4 cycles and 2 after 8 cycles.
  - Clear EN at TL=2, then re-enable -> the next increment comes a full 4 cycles later.
- Assert reset with STAT=1 and TL=32'h1234 -> the next cycle reads TL=0, TCON=0, irq=0. A write to BASE_ADDR+12 leaves the registers unchanged and reads return 0.
